uart_apb: RTL and testbench
===========================

Name: uart_apb

Overview:
- APB slave UART with TX and RX FIFOs, a programmable prescaler, and configurable frame format (5–9 data bits, parity modes, 1/2 stop bits).
- Provides internal loopback, a receive-data match flag, an RX timeout, and a maskable level interrupt.
- Sits on the peripheral APB bus; rx/tx connect to the chip pads.

Parameters:
- FAW, 4: log2 of FIFO depth (depth 16 by default).
- SC, 8: oversampling ticks per bit.

Ports:
- PCLK in 1: clock.
- PRESET in 1: asynchronous active-high reset.
- PSEL in 1: APB select.
- PENABLE in 1: APB enable.
- PWRITE in 1: 1 = write.
- PADDR in 16: byte address.
- PWDATA in 32: write data.
- PRDATA out 32: read data, combinational from PADDR.
- PREADY out 1: tied 1 (zero wait states).
- PSLVERR out 1: tied 0.
- IRQ out 1: |(RIS & IM).
- rx in 1: serial input, idle high.
- tx out 1: serial output, idle high.

Behaviour:
- Bus handshake:
  - Write commits when PSEL & PENABLE & PWRITE.
  - Read-side effects occur when PSEL & PENABLE & !PWRITE.
  - Unmapped addresses read 0 and ignore writes.
- Register map:
  - 0x000 RXDATA (RO): read pops the RX FIFO; returns 0 if empty.
  - 0x004 TXDATA (WO): [8:0] pushed to the TX FIFO; dropped if full.
  - 0x008 PR (RW, 16 bits).
  - 0x00C CTRL (RW): [0] EN, [1] TXEN, [2] RXEN, [3] LPEN, [4] GFEN.
  - 0x010 CFG (RW): [3:0] WLEN (data bits 5–9), [4] STP2, [7:5] PARITY, [13:8] TIMEOUT (bit times).
    - PARITY encoding: 000 none, 001 odd, 010 even, 100 stick-0, 101 stick-1; others = none.
  - 0x014 FIFOCTRL (RW): [3:0] TXLT, [11:8] RXLT, [16] TX flush, [24] RX flush (flush bits self-clear).
  - 0x018 FIFOS (RO): [4:0] RX level, [12:8] TX level.
  - 0x01C MATCH (RW, 9 bits).
  - 0xF00 IM, 0xF04 MIS = RIS & IM, 0xF08 RIS, 0xF0C IC (W1C, reads 0).
- Register reset values: PR=0, CTRL=0, CFG=0x3F08 (8N1, timeout 63), FIFOCTRL=0, MATCH=0, IM=0, RIS=0, FIFOs empty.
- Output reset values: tx=1, IRQ=0.
- Baud generation:
  - Tick every PR+1 PCLKs while EN=1; one bit = SC ticks.
  - baud = f_PCLK / ((PR+1)·8). Example: PR=10 at 10 MHz gives 113636 baud, 8.8 µs per bit.
- TX state machine IDLE→START→DATA→PARITY→STOP1→STOP2→IDLE:
  - Starts when EN & TXEN & TX FIFO non-empty; pops the FIFO at START.
  - Data sent LSB first, WLEN bits. PARITY state skipped when parity = none; STOP2 skipped unless STP2.
  - Clearing EN or TXEN aborts immediately: tx=1, state=IDLE.
- RX path:
  - Input selection: rx_int = LPEN ? tx : rx, followed by a 2-flop synchronizer. The tx pin stays driven during loopback.
  - States IDLE→START→DATA→PARITY→STOP→IDLE, active only when EN & RXEN.
  - Start: falling edge detected, then re-sampled at tick SC/2. If it reads high, the start is treated as false and the receiver returns to IDLE.
  - Each subsequent bit is sampled at mid-bit.
  - At STOP, the word is pushed to the RX FIFO even when FE or PRE is set.
- RIS flags are sticky: set when the condition is true, cleared by IC write 1. Condition set wins over a simultaneous clear.
  - [0] TXE: TX FIFO empty.
  - [1] RXF: RX FIFO full.
  - [2] TXB: TX level < TXLT.
  - [3] RXA: RX level > RXLT.
  - [4] MATCH: received word == MATCH.
  - [5] FE: stop bit sampled 0.
  - [6] PRE: parity mismatch.
  - [7] OR: push to a full RX FIFO; the word is discarded.
  - [8] RTO: RX idle for TIMEOUT bit times with the RX FIFO non-empty.
- FIFO rules:
  - Simultaneous push and pop on the same FIFO are both honoured; level is unchanged.
  - A flush empties the FIFO in one cycle.
  - Pointers wrap modulo the FIFO depth.

Optional Feature:
- Macro: UART_GLITCH_FILTER_EN.
- Defined: when CTRL.GFEN=1, the synchronized RX input passes through a 3-sample majority filter sampled on baud ticks before edge detection.
- Undefined: the filter is absent, CTRL[4] reads 0 and ignores writes.

Test Plan:
- PR=10, CFG=0x3F08, CTRL=0x05; drive 8N1 byte 0xA5 on rx at 8.68 µs/bit → RIS[3]=1, RXDATA=0xA5, FIFOS RX level returns to 0.
- CTRL=0, PR=21, CFG=0x3FB8, CTRL=0x03; write TXDATA 0xC3 then 0x91 → tx shows two 12-bit frames at 17.6 µs/bit: start, data LSB first, parity 1, two stop bits.
- Same setup with CTRL=0x0F (loopback); write 0xC3, 0x91; wait 417 µs → RXDATA reads 0xC3 then 0x91, FE=PRE=0.
- Receive 17 bytes with no reads → RIS[1] set, RIS[7] set; the 17th byte is lost; IC write 0x80 clears OR only.
- MATCH=0x5A, IM=0x10; receive 0x5A → IRQ=1 and MIS=0x10; receive frame with stop=0 → RIS[5]=1.
- Assert PRESET mid-transmission → tx=1 immediately, all registers return to reset values, FIFOs empty.

Source files
------------

// File: rtl/uart_apb_if.sv
// APB3 slave bus bundle for uart_apb (zero wait-state, no error responses).
`timescale 1ns/1ps
interface uart_apb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/uart_apb.sv
// uart_apb: APB UART with TX/RX FIFOs, prescaled oversampling baud generator,
// 5-9 data bits, parity, 1/2 stop bits, loopback, match flag, RX timeout, IRQ.
// Optional: UART_GLITCH_FILTER_EN adds a 3-sample majority RX filter (CTRL.GFEN).
`timescale 1ns/1ps

// Small circular FIFO; a flush clears it in one cycle and wins over push/pop.
module uart_apb_fifo #(parameter int FAW = 4, parameter int DW = 9) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [FAW:0]  level,
  output logic          full,
  output logic          empty
);
  localparam logic [FAW:0] DEPTH = (FAW+1)'(1 << FAW);
  logic [DW-1:0]  mem_q [1<<FAW];
  logic [FAW-1:0] wptr_q, rptr_q;
  logic [FAW:0]   lvl_q;
  logic           do_push, do_pop;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];
  assign level   = lvl_q;

  // storage write
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wptr_q] <= wdata;

  // pointers and level; pointers wrap naturally at the depth
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0; rptr_q <= '0; lvl_q <= '0;
    end else if (flush) begin
      wptr_q <= '0; rptr_q <= '0; lvl_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      lvl_q <= lvl_q + (FAW+1)'(do_push) - (FAW+1)'(do_pop);
    end
endmodule

module uart_apb #(parameter int FAW = 4, parameter int SC = 8) (
  input  logic      PCLK,
  input  logic      PRESET,
  uart_apb_if.slave apb,
  output logic      IRQ,
  input  logic      rx,
  output logic      tx
);
  localparam int TW = (SC > 1) ? $clog2(SC) : 1;
  localparam logic [TW-1:0] PH_LAST = TW'(SC-1);
  localparam logic [TW-1:0] PH_HALF = TW'(SC/2-1);
  localparam logic [15:0] A_RXDATA = 16'h000, A_TXDATA = 16'h004, A_PR    = 16'h008,
                          A_CTRL   = 16'h00C, A_CFG    = 16'h010, A_FCTRL = 16'h014,
                          A_FIFOS  = 16'h018, A_MATCH  = 16'h01C, A_IM    = 16'hF00,
                          A_MIS    = 16'hF04, A_RIS    = 16'hF08, A_IC    = 16'hF0C;

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_st_t;

  function automatic logic par_bit(input logic [8:0] d, input logic [2:0] m);
    case (m)
      3'b001:  return ~^d;
      3'b010:  return ^d;
      3'b101:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- registers / bus ----------------
  logic [15:0] pr_q;
  logic [3:0]  ctrl_q;
  logic [13:0] cfg_q;
  logic [3:0]  txlt_q, rxlt_q;
  logic [8:0]  match_q, im_q, ris_q, ris_d, cond;
  logic        wr_en, rd_en, en, txen, rxen, lpen;
  logic [3:0]  wlen;
  logic [8:0]  mask;
  logic [2:0]  par;
  logic        par_en, stp2;
  logic [31:0] prdata;

  assign wr_en = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_en = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign {lpen, rxen, txen, en} = ctrl_q;
  assign stp2   = cfg_q[4];
  assign par    = cfg_q[7:5];
  assign par_en = (par == 3'b001) | (par == 3'b010) | (par == 3'b100) | (par == 3'b101);
  assign mask   = 9'h1FF >> (4'd9 - wlen);

  // word length clamped to the supported 5..9 range
  always_comb begin
    wlen = cfg_q[3:0];
    if (cfg_q[3:0] < 4'd5)      wlen = 4'd5;
    else if (cfg_q[3:0] > 4'd9) wlen = 4'd9;
  end

  // configuration register writes
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      pr_q <= '0; ctrl_q <= '0; cfg_q <= 14'h3F08;
      txlt_q <= '0; rxlt_q <= '0; match_q <= '0; im_q <= '0;
    end else if (wr_en) begin
      case (apb.PADDR)
        A_PR:    pr_q    <= apb.PWDATA[15:0];
        A_CTRL:  ctrl_q  <= apb.PWDATA[3:0];
        A_CFG:   cfg_q   <= apb.PWDATA[13:0];
        A_FCTRL: begin txlt_q <= apb.PWDATA[3:0]; rxlt_q <= apb.PWDATA[11:8]; end
        A_MATCH: match_q <= apb.PWDATA[8:0];
        A_IM:    im_q    <= apb.PWDATA[8:0];
        default: ;
      endcase
    end

  // ---------------- FIFOs ----------------
  logic [8:0]   tx_rdata, rx_rdata, rx_word;
  logic [FAW:0] tx_lvl, rx_lvl;
  logic         tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_pop, rx_done;

  assign rx_pop = rd_en & (apb.PADDR == A_RXDATA);

  uart_apb_fifo #(.FAW(FAW), .DW(9)) u_txf (
    .clk(PCLK), .rst(PRESET), .push(wr_en & (apb.PADDR == A_TXDATA)), .pop(tx_pop),
    .flush(wr_en & (apb.PADDR == A_FCTRL) & apb.PWDATA[16]), .wdata(apb.PWDATA[8:0]),
    .rdata(tx_rdata), .level(tx_lvl), .full(tx_full), .empty(tx_empty));

  uart_apb_fifo #(.FAW(FAW), .DW(9)) u_rxf (
    .clk(PCLK), .rst(PRESET), .push(rx_done), .pop(rx_pop),
    .flush(wr_en & (apb.PADDR == A_FCTRL) & apb.PWDATA[24]), .wdata(rx_word),
    .rdata(rx_rdata), .level(rx_lvl), .full(rx_full), .empty(rx_empty));

  // ---------------- baud tick ----------------
  logic [15:0] bcnt_q;
  logic        tick;
  assign tick = en && (bcnt_q >= pr_q);

  // free-running prescaler, held in reset while the UART is disabled
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET)             bcnt_q <= '0;
    else if (!en || tick)   bcnt_q <= '0;
    else                    bcnt_q <= bcnt_q + 16'd1;

  // ---------------- transmitter ----------------
  tx_st_t        tx_st_q, tx_st_d;
  logic [TW-1:0] tx_ph_q, tx_ph_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic          tx_par_q, tx_par_d, tx_q, tx_d, tx_go, tx_end;

  assign tx_go  = en & txen;
  assign tx_end = tick && (tx_ph_q == PH_LAST);

  // TX next state; the serial output is registered from the next state
  always_comb begin
    tx_st_d = tx_st_q; tx_ph_d = tx_ph_q; tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q; tx_par_d = tx_par_q; tx_pop = 1'b0;
    if (tick) tx_ph_d = tx_end ? '0 : tx_ph_q + 1'b1;
    case (tx_st_q)
      T_IDLE: begin
        tx_ph_d = '0;
        if (tx_go && !tx_empty) begin
          tx_st_d  = T_START; tx_pop = 1'b1; tx_bit_d = '0;
          tx_sh_d  = tx_rdata & mask;
          tx_par_d = par_bit(tx_rdata & mask, par);
        end
      end
      T_START: if (tx_end) tx_st_d = T_DATA;
      T_DATA: if (tx_end) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 4'd1;
        if (tx_bit_q == wlen - 4'd1) tx_st_d = par_en ? T_PAR : T_STOP1;
      end
      T_PAR:   if (tx_end) tx_st_d = T_STOP1;
      T_STOP1: if (tx_end) tx_st_d = stp2 ? T_STOP2 : T_IDLE;
      T_STOP2: if (tx_end) tx_st_d = T_IDLE;
      default: tx_st_d = T_IDLE;
    endcase
    if (!tx_go) begin tx_st_d = T_IDLE; tx_ph_d = '0; end
    case (tx_st_d)
      T_START: tx_d = 1'b0;
      T_DATA:  tx_d = tx_sh_d[0];
      T_PAR:   tx_d = tx_par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // TX state register
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      tx_st_q <= T_IDLE; tx_ph_q <= '0; tx_bit_q <= '0;
      tx_sh_q <= '0; tx_par_q <= 1'b0; tx_q <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d; tx_ph_q <= tx_ph_d; tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d; tx_q <= tx_d;
    end

  assign tx = tx_q;

  // ---------------- receiver input conditioning ----------------
  logic [1:0] sync_q;
  logic       rx_f, rx_prev_q;

  // loopback mux then two-flop synchronizer
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], lpen ? tx_q : rx};

`ifdef UART_GLITCH_FILTER_EN
  logic       gfen_q;
  logic [2:0] gf_q;
  // GFEN bit and the tick-sampled majority window
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      gfen_q <= 1'b0; gf_q <= 3'b111;
    end else begin
      if (wr_en && apb.PADDR == A_CTRL) gfen_q <= apb.PWDATA[4];
      if (tick) gf_q <= {gf_q[1:0], sync_q[1]};
    end
  assign rx_f = gfen_q ? ((gf_q[0] & gf_q[1]) | (gf_q[0] & gf_q[2]) | (gf_q[1] & gf_q[2]))
                       : sync_q[1];
`else
  logic gfen_q;
  assign gfen_q = 1'b0;
  assign rx_f   = sync_q[1];
`endif

  // ---------------- receiver ----------------
  rx_st_t        rx_st_q, rx_st_d;
  logic [TW-1:0] rx_ph_q, rx_ph_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [8:0]    rx_sh_q, rx_sh_d;
  logic          rx_go, rx_mid, fe_evt, pre_evt;

  assign rx_go   = en & rxen;
  assign rx_mid  = tick && (rx_ph_q == PH_LAST);
  assign rx_word = rx_sh_q >> (4'd9 - wlen);

  // RX next state: start re-check at half bit, then one sample per bit
  always_comb begin
    rx_st_d = rx_st_q; rx_ph_d = rx_ph_q; rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q;
    rx_done = 1'b0; fe_evt = 1'b0; pre_evt = 1'b0;
    if (tick) rx_ph_d = rx_ph_q + 1'b1;
    case (rx_st_q)
      R_IDLE: begin
        rx_ph_d = '0;
        if (rx_prev_q && !rx_f) rx_st_d = R_START;
      end
      R_START: if (tick && rx_ph_q == PH_HALF) begin
        rx_ph_d = '0; rx_bit_d = '0;
        rx_st_d = rx_f ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_mid) begin
        rx_ph_d  = '0;
        rx_sh_d  = {rx_f, rx_sh_q[8:1]};
        rx_bit_d = rx_bit_q + 4'd1;
        if (rx_bit_q == wlen - 4'd1) rx_st_d = par_en ? R_PAR : R_STOP;
      end
      R_PAR: if (rx_mid) begin
        rx_ph_d = '0;
        pre_evt = (rx_f != par_bit(rx_word, par));
        rx_st_d = R_STOP;
      end
      R_STOP: if (rx_mid) begin
        rx_ph_d = '0; fe_evt = ~rx_f; rx_done = 1'b1; rx_st_d = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
    if (!rx_go) begin
      rx_st_d = R_IDLE; rx_ph_d = '0; rx_done = 1'b0; fe_evt = 1'b0; pre_evt = 1'b0;
    end
  end

  // RX state register
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      rx_st_q <= R_IDLE; rx_ph_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0; rx_prev_q <= 1'b1;
    end else begin
      rx_st_q <= rx_st_d; rx_ph_q <= rx_ph_d; rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d; rx_prev_q <= rx_f;
    end

  // ---------------- RX timeout ----------------
  logic [6+TW-1:0] rto_q, rto_tgt;
  logic            rto_run;
  assign rto_tgt = (6+TW)'(cfg_q[13:8]) * (6+TW)'(SC);
  assign rto_run = (rx_st_q == R_IDLE) && rx_go && !rx_empty;

  // counts idle ticks while data waits in the RX FIFO, saturating at the target
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET)                        rto_q <= '0;
    else if (!rto_run)                 rto_q <= '0;
    else if (tick && rto_q < rto_tgt)  rto_q <= rto_q + 1'b1;

  // ---------------- interrupts ----------------
  always_comb begin
    cond[0] = tx_empty;
    cond[1] = rx_full;
    cond[2] = tx_lvl < (FAW+1)'(txlt_q);
    cond[3] = rx_lvl > (FAW+1)'(rxlt_q);
    cond[4] = rx_done && (rx_word == match_q);
    cond[5] = fe_evt;
    cond[6] = pre_evt;
    cond[7] = rx_done && rx_full && !rx_pop;
    cond[8] = rto_run && (cfg_q[13:8] != 6'd0) && (rto_q >= rto_tgt);
    ris_d   = ris_q;
    if (wr_en && apb.PADDR == A_IC) ris_d = ris_q & ~apb.PWDATA[8:0];
    ris_d   = ris_d | cond;
  end

  // sticky raw status; a live condition beats a same-cycle clear
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) ris_q <= '0;
    else        ris_q <= ris_d;

  assign IRQ = |(ris_q & im_q);

  // ---------------- read mux ----------------
  always_comb begin
    prdata = '0;
    case (apb.PADDR)
      A_RXDATA: prdata[8:0]   = rx_empty ? 9'd0 : rx_rdata;
      A_PR:     prdata[15:0]  = pr_q;
      A_CTRL:   prdata[4:0]   = {gfen_q, ctrl_q};
      A_CFG:    prdata[13:0]  = cfg_q;
      A_FCTRL:  begin prdata[3:0] = txlt_q; prdata[11:8] = rxlt_q; end
      A_FIFOS:  begin prdata[FAW:0] = rx_lvl; prdata[8 +: FAW+1] = tx_lvl; end
      A_MATCH:  prdata[8:0]   = match_q;
      A_IM:     prdata[8:0]   = im_q;
      A_MIS:    prdata[8:0]   = ris_q & im_q;
      A_RIS:    prdata[8:0]   = ris_q;
      default:  prdata = '0;
    endcase
  end

  assign apb.PRDATA = prdata;
endmodule

// File: tb/tb_uart_apb.sv
// Directed bench for uart_apb: register map, RX 8N1, TX 8-stick1-2, loopback,
// overrun, match/IRQ, framing error, reset during transmission.
`timescale 1ns/1ps
module tb_uart_apb;
  logic PCLK = 1'b0, PRESET = 1'b1, rx = 1'b1;
  logic tx, IRQ;
  logic [31:0] d;
  int n_cmp = 0, n_err = 0;

  uart_apb_if apb();
  uart_apb #(.FAW(4), .SC(8)) dut (.PCLK(PCLK), .PRESET(PRESET), .apb(apb.slave),
                                   .IRQ(IRQ), .rx(rx), .tx(tx));

  always #50 PCLK = ~PCLK;   // 10 MHz

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [15:0] a, input logic [31:0] v);
    @(negedge PCLK);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = v;
    @(negedge PCLK); apb.PENABLE = 1'b1;
    @(negedge PCLK); apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [15:0] a, output logic [31:0] v);
    @(negedge PCLK);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
    @(negedge PCLK); apb.PENABLE = 1'b1;
    #1 v = apb.PRDATA;
    @(negedge PCLK); apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  // combinational read with no bus cycle (used while reset is held)
  task automatic peek(input logic [15:0] a, output logic [31:0] v);
    apb.PADDR = a; #1 v = apb.PRDATA;
  endtask

  task automatic send_bits(input logic [11:0] b, input int n, input int bt_ns);
    for (int i = 0; i < n; i++) begin rx = b[i]; #(bt_ns); end
    rx = 1'b1;
  endtask

  task automatic wait_tx_low();
    for (int i = 0; i < 4000; i++) begin
      if (tx === 1'b0) break;
      @(posedge PCLK);
    end
    #1 chk("tx_start_seen", {31'd0, tx}, 32'd0);
  endtask

  // capture one 12-bit frame: start, 8 data, parity, 2 stop; 17.6 us per bit
  task automatic grab_tx_frame(output logic [11:0] f);
    wait_tx_low();
    #8800;
    for (int i = 0; i < 12; i++) begin
      f[i] = tx;
      if (i < 11) #17600;
    end
  endtask

  logic [11:0] fr;
  logic [7:0]  byt;

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;

    // reset state, observed while reset is held
    #220;
    chk("rst_tx",  {31'd0, tx},  32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    peek(16'h010, d); chk("rst_cfg",   d, 32'h3F08);
    peek(16'hF08, d); chk("rst_ris",   d, 32'h0);
    peek(16'h018, d); chk("rst_fifos", d, 32'h0);
    @(negedge PCLK); PRESET = 1'b0;

    // register map basics
    apb_wr(16'h008, 32'h0001_1234); apb_rd(16'h008, d); chk("pr_rw", d, 32'h1234);
    apb_wr(16'h100, 32'hFFFF_FFFF); apb_rd(16'h100, d); chk("unmapped", d, 32'h0);
    apb_wr(16'h00C, 32'h1F); apb_rd(16'h00C, d);
`ifdef UART_GLITCH_FILTER_EN
    chk("ctrl_rw", d, 32'h1F);
`else
    chk("ctrl_rw", d, 32'h0F);
`endif
    apb_wr(16'h00C, 32'h0);
    apb_wr(16'h014, 32'h0101_0305); apb_rd(16'h014, d); chk("fifoctrl_rw", d, 32'h0305);
    apb_wr(16'h014, 32'h0);
    apb_rd(16'h000, d); chk("rxdata_empty", d, 32'h0);

    // RX 8N1 0xA5 at 8.68 us/bit
    apb_wr(16'h008, 10); apb_wr(16'h010, 32'h3F08); apb_wr(16'h00C, 32'h05);
    apb_wr(16'hF0C, 32'h1FF);
    send_bits({2'b11, 8'hA5, 1'b0}, 10, 8680);
    apb_rd(16'hF08, d); chk("rxa_flag",  (d >> 3) & 1, 32'd1);
    apb_rd(16'h018, d); chk("rx_lvl_1",  d, 32'h01);
    apb_rd(16'h000, d); chk("rx_a5",     d, 32'hA5);
    apb_rd(16'h018, d); chk("rx_lvl_0",  d, 32'h00);

    // TX two frames, 8 data, stick-1 parity, 2 stop
    apb_wr(16'h00C, 0); apb_wr(16'h008, 21); apb_wr(16'h010, 32'h3FB8); apb_wr(16'h00C, 32'h03);
    apb_wr(16'h004, 32'hC3); apb_wr(16'h004, 32'h91);
    grab_tx_frame(fr); chk("tx_frame_c3", {20'd0, fr}, {20'd0, 3'b111, 8'hC3, 1'b0});
    grab_tx_frame(fr); chk("tx_frame_91", {20'd0, fr}, {20'd0, 3'b111, 8'h91, 1'b0});

    // loopback
    #20000;
    apb_wr(16'h00C, 0); apb_wr(16'hF0C, 32'h1FF); apb_wr(16'h00C, 32'h0F);
    apb_wr(16'h004, 32'hC3); apb_wr(16'h004, 32'h91);
    #417000;
    apb_rd(16'h000, d); chk("lb_c3", d, 32'hC3);
    apb_rd(16'h000, d); chk("lb_91", d, 32'h91);
    apb_rd(16'hF08, d); chk("lb_fe_pre", d & 32'h60, 32'h0);

    // overrun: 17 bytes with no reads
    apb_wr(16'h00C, 0); apb_wr(16'h008, 10); apb_wr(16'h010, 32'h3F08);
    apb_wr(16'h014, 32'h0100_0000); apb_wr(16'hF0C, 32'h1FF); apb_wr(16'h00C, 32'h05);
    for (int i = 0; i < 17; i++) begin
      byt = 8'(i + 1);
      send_bits({2'b11, byt, 1'b0}, 10, 8800);
    end
    repeat (20) @(posedge PCLK);
    apb_rd(16'hF08, d);  chk("ovr_rxf_or", d & 32'h82, 32'h82);
    apb_rd(16'h018, d);  chk("ovr_level",  d, 32'h10);
    apb_wr(16'hF0C, 32'h80);
    apb_rd(16'hF08, d);  chk("ic_or_only", d & 32'h82, 32'h02);
    for (int i = 0; i < 16; i++) begin
      apb_rd(16'h000, d); chk("ovr_data", d, 32'(i + 1));
    end
    apb_rd(16'h000, d); chk("ovr_17th_lost", d, 32'h0);

    // match + IRQ, then framing error
    apb_wr(16'hF0C, 32'h1FF); apb_wr(16'h01C, 32'h5A); apb_wr(16'hF00, 32'h10);
    #1 chk("irq_idle", {31'd0, IRQ}, 32'd0);
    send_bits({2'b11, 8'h5A, 1'b0}, 10, 8800);
    repeat (5) @(posedge PCLK);
    #1 chk("irq_match", {31'd0, IRQ}, 32'd1);
    apb_rd(16'hF04, d); chk("mis_match", d, 32'h10);
    send_bits({2'b10, 8'h33, 1'b0}, 10, 8800);
    repeat (5) @(posedge PCLK);
    apb_rd(16'hF08, d); chk("fe_flag", (d >> 5) & 1, 32'd1);
    apb_rd(16'h000, d); chk("rx_5a", d, 32'h5A);
    apb_rd(16'h000, d); chk("rx_fe_word", d, 32'h33);

    // reset in the middle of a frame
    apb_wr(16'h00C, 0); apb_wr(16'h008, 21); apb_wr(16'h00C, 32'h03);
    apb_wr(16'h004, 32'h00);
    wait_tx_low();
    #3000;
    PRESET = 1'b1;
    #1 chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_irq", {31'd0, IRQ}, 32'd0);
    peek(16'h008, d); chk("rst_pr",    d, 32'h0);
    peek(16'h00C, d); chk("rst_ctrl",  d, 32'h0);
    peek(16'h010, d); chk("rst_cfg2",  d, 32'h3F08);
    peek(16'h01C, d); chk("rst_match", d, 32'h0);
    peek(16'hF00, d); chk("rst_im",    d, 32'h0);
    peek(16'h018, d); chk("rst_fifos2", d, 32'h0);
    @(negedge PCLK); @(negedge PCLK); PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("post_rst_tx", {31'd0, tx}, 32'd1);
    apb_rd(16'hF08, d); chk("post_rst_txe", d, 32'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
